bnn_feature_averager: RTL and testbench
=======================================

Name: bnn_feature_averager

Overview:
Upstream front-end of the microgreen BNN classifier.
- Accepts raw 4-bit sensor samples, each tagged with a channel id (height, color, width, stem), over a valid/ready handshake.
- Averages 2^LOG2_SAMPLES samples per channel and presents one packed 16-bit feature frame to the classifier over a second valid/ready handshake.
- Suppresses single-sample sensor noise before the classifier binarizes each feature at >7.

Parameters:
- LOG2_SAMPLES, 2, log2 of samples averaged per channel per frame; legal range 0..4.
- ACC_W, 4+LOG2_SAMPLES, accumulator width (derived; do not override).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- ena  input  1  global enable; when low, all state is frozen and no handshake completes
- s_valid  input  1  sample valid
- s_ready  output  1  sample ready
- s_chan  input  2  channel id: 0 height, 1 color, 2 width, 3 stem
- s_data  input  4  unsigned raw sample
- f_valid  output  1  feature frame valid
- f_ready  input  1  downstream ready
- f_data  output  16  packed frame: [3:0] height, [7:4] color, [11:8] width, [15:12] stem
- dropped  output  1  sticky: at least one sample arrived for an already-full channel during the current frame
- busy  output  1  high when any channel count is nonzero or f_valid is high

Behaviour:
- Reset values: f_valid=0, f_data=0, dropped=0, busy=0. All accumulators and counts 0. State COLLECT.
- s_ready = ena && (state==COLLECT). This is combinational from registered state only; there is no path from s_valid.
- A sample is accepted on a rising clk edge when s_valid && s_ready.
- Sample handling in COLLECT:
  - If cnt[s_chan] < N (N = 2^LOG2_SAMPLES): acc[s_chan] += s_data and cnt[s_chan]++.
  - Otherwise the sample is discarded and dropped is set to 1.
- Arithmetic: unsigned, ACC_W bits; overflow is impossible (max 15*N).
- Frame complete: at the edge where the accepted sample makes every cnt equal N, the block registers f_data[ch] = acc_next[ch] >> LOG2_SAMPLES (truncation) and goes to OUTPUT. f_valid=1 on the following cycle.
- Latency: 1 cycle from the final accepted sample to f_valid.
- OUTPUT state:
  - s_ready=0.
  - f_valid and f_data are held stable until f_valid && f_ready && ena.
  - On that edge: f_valid=0, all acc/cnt cleared, dropped cleared, back to COLLECT.
  - The first new sample can be accepted on the next cycle.
- ena low in any state: no register changes; f_valid stays at its current value; f_ready is ignored.
- Channel order is free. Interleaved or bursty arrival gives the same result.
- LOG2_SAMPLES=0: each channel completes after one sample, and f_data equals the raw samples.
- Reset asserted mid-frame or in OUTPUT: partial sums are discarded immediately (asynchronous). No frame is emitted.

Optional Feature:
- Macro: BNN_FEATURE_ROUND_EN.
- Defined: f_data[ch] = (acc + 2^(LOG2_SAMPLES-1)) >> LOG2_SAMPLES, i.e. round half up. The result is always ≤15, so no saturation is needed. With LOG2_SAMPLES=0 the added term is 0.
- Undefined: truncating average as described above.
- Rounding matters at the downstream >7 threshold. Example: samples 7,8,8,7 give mean 7.5; rounded result is 8, truncated result is 7.

Decomposition:
- Package bnn_pkg:
  - FEAT_W=4.
  - Channel id constants CH_HEIGHT=0, CH_COLOR=1, CH_WIDTH=2, CH_STEM=3.
  - Frame field offsets.
  - State enum {COLLECT, OUTPUT}.
- Sub-module bnn_chan_acc, instantiated 4 times:
  - Holds one accumulator and its count.
  - Inputs: add_en, clr, data.
  - Outputs: full, acc_next, avg (rounding applied under the macro).
- Top level: handshake, FSM, dropped flag, packing.

Test Plan:
- LOG2=2: height 8,8,8,8; color 3,3,3,3; width 15,15,15,15; stem 0,0,0,0, round-robin → f_valid one cycle after the 16th accept, f_data=16'h0F38, dropped=0.
- Hold f_ready=0 for 10 cycles → f_valid and f_data stable, s_ready=0. Raise f_ready → f_valid falls next edge, busy=0, s_ready=1.
- Color samples 7,8,8,7 with other channels all 0 → color field 7 without macro, 8 with BNN_FEATURE_ROUND_EN.
- Fifth height sample before other channels complete → discarded, dropped=1, height average unchanged. dropped clears on frame handoff.
- Toggle ena=0 mid-frame for 5 cycles with s_valid=1 → no accepts, counts frozen. Frame completes correctly after ena returns.
- Assert rst_n low after 9 accepts and release → no f_valid. A fresh 16-sample frame then averages only the new samples.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared types and constants for the microgreen BNN front-end.
package bnn_pkg;

   localparam int FEAT_W = 4;
   localparam int NUM_CH = 4;

   localparam logic [1:0] CH_HEIGHT = 2'd0;
   localparam logic [1:0] CH_COLOR  = 2'd1;
   localparam logic [1:0] CH_WIDTH  = 2'd2;
   localparam logic [1:0] CH_STEM   = 2'd3;

   localparam int OFS_HEIGHT = 0;
   localparam int OFS_COLOR  = 4;
   localparam int OFS_WIDTH  = 8;
   localparam int OFS_STEM   = 12;

   typedef enum logic {
      COLLECT = 1'b0,
      OUTPUT  = 1'b1
   } state_t;

endpackage

// File: rtl/bnn_chan_acc.sv
// One channel's running sum and sample count for the feature averager.
// Optional macro BNN_FEATURE_ROUND_EN selects round-half-up averaging instead of truncation.
module bnn_chan_acc
   import bnn_pkg::*;
#(
   parameter int LOG2_SAMPLES = 2,
   parameter int ACC_W        = 4 + LOG2_SAMPLES
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              add_en,
   input  logic              clr,
   input  logic [FEAT_W-1:0] data,
   output logic              full,
   output logic              full_next,
   output logic              nonzero,
   output logic [ACC_W-1:0]  acc_next,
   output logic [FEAT_W-1:0] avg
);

   localparam int              CNT_W = LOG2_SAMPLES + 1;
   localparam logic [CNT_W-1:0] N    = CNT_W'(1) << LOG2_SAMPLES;

   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cntNext;

   assign acc_next  = r_acc + (add_en ? ACC_W'(data) : '0);
   assign w_cntNext = r_cnt + CNT_W'(add_en);
   assign full      = (r_cnt == N);
   assign full_next = (w_cntNext == N);
   assign nonzero   = (r_cnt != '0);

`ifdef BNN_FEATURE_ROUND_EN
   // Half of N is added before the shift; 15*N + N/2 still fits in ACC_W.
   localparam logic [ACC_W-1:0] HALF = ACC_W'((1 << LOG2_SAMPLES) >> 1);
   logic [ACC_W-1:0] w_rounded;
   assign w_rounded = acc_next + HALF;
   assign avg       = FEAT_W'(w_rounded >> LOG2_SAMPLES);
`else
   assign avg       = FEAT_W'(acc_next >> LOG2_SAMPLES);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (clr) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (add_en) begin
         r_acc <= acc_next;
         r_cnt <= w_cntNext;
      end
   end

endmodule

// File: rtl/bnn_feature_averager.sv
// Averages 2^LOG2_SAMPLES samples per sensor channel into one packed feature frame.
// Optional macro BNN_FEATURE_ROUND_EN (in bnn_chan_acc) enables round-half-up averages.
module bnn_feature_averager
   import bnn_pkg::*;
#(
   parameter int LOG2_SAMPLES = 2,
   parameter int ACC_W        = 4 + LOG2_SAMPLES
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [1:0]        s_chan,
   input  logic [FEAT_W-1:0] s_data,
   output logic              f_valid,
   input  logic              f_ready,
   output logic [15:0]       f_data,
   output logic              dropped,
   output logic              busy
);

   state_t r_state;
   state_t w_nextState;
   logic   r_fValid;
   logic   [15:0] r_fData;
   logic   r_dropped;

   logic [NUM_CH-1:0] w_addEn;
   logic [NUM_CH-1:0] w_full;
   logic [NUM_CH-1:0] w_fullNext;
   logic [NUM_CH-1:0] w_nonzero;
   logic [ACC_W-1:0]  w_accNext [NUM_CH];
   logic [FEAT_W-1:0] w_avg     [NUM_CH];
   logic [15:0]       w_packed;
   logic              w_accept;
   logic              w_drop;
   logic              w_complete;
   logic              w_handoff;

   assign s_ready    = ena && (r_state == COLLECT);
   assign w_accept   = s_valid && s_ready;
   assign w_drop     = w_accept && w_full[s_chan];
   // The frame closes on the accept that brings the last unfilled channel to N.
   assign w_complete = w_accept && (&w_fullNext);
   assign w_handoff  = ena && (r_state == OUTPUT) && r_fValid && f_ready;

   for (genvar g_chan = 0; g_chan < NUM_CH; g_chan++) begin : g_acc
      assign w_addEn[g_chan] = w_accept && (s_chan == 2'(g_chan)) && !w_full[g_chan];
      assign w_packed[g_chan*FEAT_W +: FEAT_W] = w_avg[g_chan];

      bnn_chan_acc #(
         .LOG2_SAMPLES(LOG2_SAMPLES),
         .ACC_W       (ACC_W)
      ) u_chanAcc (
         .clk      (clk),
         .rst_n    (rst_n),
         .add_en   (w_addEn[g_chan]),
         .clr      (w_handoff),
         .data     (s_data),
         .full     (w_full[g_chan]),
         .full_next(w_fullNext[g_chan]),
         .nonzero  (w_nonzero[g_chan]),
         .acc_next (w_accNext[g_chan]),
         .avg      (w_avg[g_chan])
      );
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         COLLECT: if (w_complete) w_nextState = OUTPUT;
         OUTPUT:  if (w_handoff)  w_nextState = COLLECT;
         default: w_nextState = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= COLLECT;
         r_fValid  <= 1'b0;
         r_fData   <= '0;
         r_dropped <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (w_complete) begin
            r_fValid <= 1'b1;
            r_fData  <= w_packed;
         end else if (w_handoff) begin
            r_fValid <= 1'b0;
         end
         if (w_handoff) r_dropped <= 1'b0;
         else if (w_drop) r_dropped <= 1'b1;
      end
   end

   assign f_valid = r_fValid;
   assign f_data  = r_fData;
   assign dropped = r_dropped;
   assign busy    = (|w_nonzero) || r_fValid;

endmodule

// File: tb/tb_bnn_feature_averager.sv
// Self-checking bench for bnn_feature_averager (LOG2_SAMPLES=2) against a frame-level model.
module tb_bnn_feature_averager;

   localparam int LOG2 = 2;
   localparam int N    = 1 << LOG2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b1;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [1:0]  s_chan = 2'd0;
   logic [3:0]  s_data = 4'd0;
   logic        f_valid;
   logic        f_ready = 1'b0;
   logic [15:0] f_data;
   logic        dropped;
   logic        busy;

   int nChecks = 0;
   int nPass   = 0;
   bit doneRun = 1'b0;

   // Behavioural model: per-channel sums and counts plus the pending frame.
   int          mSum [4];
   int          mCnt [4];
   bit          mOutValid;
   bit          mDropped;
   logic [15:0] mFrame;

   bnn_feature_averager #(.LOG2_SAMPLES(LOG2)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .s_chan (s_chan),
      .s_data (s_data),
      .f_valid(f_valid),
      .f_ready(f_ready),
      .f_data (f_data),
      .dropped(dropped),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   function automatic int averageOf(int sum);
`ifdef BNN_FEATURE_ROUND_EN
      return (sum + N / 2) / N;
`else
      return sum / N;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      nChecks++;
      if (actual === expected) nPass++;
      else $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, expected, $time);
   endtask

   // Model advances on the same edges as the DUT, using only the bench's inputs.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 4; c++) begin
            mSum[c] = 0;
            mCnt[c] = 0;
         end
         mOutValid = 1'b0;
         mDropped  = 1'b0;
         mFrame    = 16'h0000;
      end else if (ena) begin
         if (mOutValid) begin
            if (f_ready) begin
               for (int c = 0; c < 4; c++) begin
                  mSum[c] = 0;
                  mCnt[c] = 0;
               end
               mOutValid = 1'b0;
               mDropped  = 1'b0;
            end
         end else if (s_valid) begin
            if (mCnt[s_chan] == N) begin
               mDropped = 1'b1;
            end else begin
               mSum[s_chan] += int'(s_data);
               mCnt[s_chan] += 1;
               if (mCnt[0] == N && mCnt[1] == N && mCnt[2] == N && mCnt[3] == N) begin
                  for (int c = 0; c < 4; c++) mFrame[c*4 +: 4] = 4'(averageOf(mSum[c]));
                  mOutValid = 1'b1;
               end
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (rst_n && !doneRun) begin
         checkOutput("s_ready", 16'(s_ready), 16'(ena && !mOutValid));
         checkOutput("f_valid", 16'(f_valid), 16'(mOutValid));
         checkOutput("dropped", 16'(dropped), 16'(mDropped));
         checkOutput("busy", 16'(busy),
                     16'(mOutValid || mCnt[0] != 0 || mCnt[1] != 0 || mCnt[2] != 0 || mCnt[3] != 0));
         if (mOutValid) checkOutput("f_data", f_data, mFrame);
      end
   end

   task automatic applyStimulus(input logic [1:0] ch, input logic [3:0] d);
      bit got;
      got = 1'b0;
      s_valid = 1'b1;
      s_chan  = ch;
      s_data  = d;
      for (int t = 0; t < 200 && !got; t++) begin
         @(negedge clk);
         if (s_ready) got = 1'b1;
      end
      if (!got) checkOutput("accept_timeout", 16'(0), 16'(1));
      @(posedge clk);
      #1 s_valid = 1'b0;
   endtask

   task automatic sendFrame(input logic [15:0] vals [16]);
      for (int i = 0; i < 16; i++) applyStimulus(2'(i % 4), vals[i][3:0]);
   endtask

   task automatic drainFrame(input string name, input logic [15:0] expected);
      bit got;
      got = 1'b0;
      f_ready = 1'b1;
      for (int t = 0; t < 200 && !got; t++) begin
         @(negedge clk);
         if (f_valid) got = 1'b1;
      end
      if (!got) checkOutput({name, "_timeout"}, 16'(0), 16'(1));
      else checkOutput(name, f_data, expected);
      @(posedge clk);
      #1 f_ready = 1'b0;
   endtask

   logic [15:0] frameVals [16];
   logic [15:0] colorExp;

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("reset_f_data", f_data, 16'h0000);
      checkOutput("reset_busy", 16'(busy), 16'(0));
      @(posedge clk);
      #1;

      // Frame 1: height 8, color 3, width 15, stem 0, round-robin.
      for (int i = 0; i < 16; i++) begin
         case (i % 4)
            0: frameVals[i] = 16'd8;
            1: frameVals[i] = 16'd3;
            2: frameVals[i] = 16'd15;
            default: frameVals[i] = 16'd0;
         endcase
      end
      sendFrame(frameVals);
      @(negedge clk);
      checkOutput("latency_f_valid", 16'(f_valid), 16'(1));
      checkOutput("frame1_data", f_data, 16'h0F38);
      checkOutput("frame1_dropped", 16'(dropped), 16'(0));
      repeat (10) @(negedge clk);
      checkOutput("hold_f_valid", 16'(f_valid), 16'(1));
      checkOutput("hold_f_data", f_data, 16'h0F38);
      checkOutput("hold_s_ready", 16'(s_ready), 16'(0));
      @(posedge clk);
      #1 f_ready = 1'b1;
      @(posedge clk);
      #1 f_ready = 1'b0;
      @(negedge clk);
      checkOutput("handoff_f_valid", 16'(f_valid), 16'(0));
      checkOutput("handoff_busy", 16'(busy), 16'(0));
      checkOutput("handoff_s_ready", 16'(s_ready), 16'(1));
      @(posedge clk);
      #1;

      // Color 7,8,8,7 with other channels zero: rounding decides 7 versus 8.
      for (int i = 0; i < 16; i++) frameVals[i] = 16'd0;
      frameVals[1] = 16'd7; frameVals[5] = 16'd8; frameVals[9] = 16'd8; frameVals[13] = 16'd7;
`ifdef BNN_FEATURE_ROUND_EN
      colorExp = 16'h0080;
`else
      colorExp = 16'h0070;
`endif
      sendFrame(frameVals);
      drainFrame("color_round", colorExp);

      // Fifth height sample is discarded and flags dropped.
      for (int i = 0; i < 4; i++) applyStimulus(2'd0, 4'd4);
      applyStimulus(2'd0, 4'd15);
      @(negedge clk);
      checkOutput("drop_flag", 16'(dropped), 16'(1));
      @(posedge clk);
      #1;
      for (int c = 1; c < 4; c++)
         for (int i = 0; i < 4; i++) applyStimulus(2'(c), 4'd0);
      drainFrame("drop_frame", 16'h0004);
      @(negedge clk);
      checkOutput("drop_cleared", 16'(dropped), 16'(0));
      @(posedge clk);
      #1;

      // Enable low mid-frame with s_valid high: nothing is accepted.
      for (int i = 0; i < 6; i++) applyStimulus(2'(i % 4), 4'd12);
      ena = 1'b0;
      s_valid = 1'b1;
      s_chan = 2'd3;
      s_data = 4'd15;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("ena_low_s_ready", 16'(s_ready), 16'(0));
      end
      @(posedge clk);
      #1 ena = 1'b1;
      s_valid = 1'b0;
      for (int i = 6; i < 16; i++) applyStimulus(2'(i % 4), 4'd12);
      drainFrame("ena_frame", 16'hCCCC);

      // Reset after nine accepts discards partial sums.
      for (int i = 0; i < 9; i++) applyStimulus(2'(i % 4), 4'd15);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("rst_f_valid", 16'(f_valid), 16'(0));
      checkOutput("rst_busy", 16'(busy), 16'(0));
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 16; i++) frameVals[i] = 16'(i % 4 + 1);
      sendFrame(frameVals);
      drainFrame("post_reset_frame", 16'h4321);

      // Randomized traffic: bursty samples, random back-pressure and enable.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         s_valid = ($urandom_range(0, 3) != 0);
         s_chan  = 2'($urandom_range(0, 3));
         s_data  = 4'($urandom_range(0, 15));
         f_ready = ($urandom_range(0, 2) != 0);
         ena     = ($urandom_range(0, 9) != 0);
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      ena = 1'b1;
      f_ready = 1'b0;
      @(negedge clk);
      doneRun = 1'b1;
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
